// File: rtl/main_memory_responder_pkg.sv
// Shared constants and FSM state type for the main-memory responder.
// Line geometry and address width are common to the cache side and the memory side.
package mem_if_pkg;
    localparam int LINE_BITS   = 512;
    localparam int OFFSET_BITS = 6;
    localparam int ADDR_BITS   = 32;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT
    } mem_state_t;
endpackage

// File: rtl/main_memory_responder_if.sv
// Miss/write-back handshake between the cache (master) and main memory (slave).
interface main_memory_responder_if #(
    parameter int LINE_BITS = mem_if_pkg::LINE_BITS
);
    import mem_if_pkg::*;

    logic                 ask_for_data;
    logic [ADDR_BITS-1:0] address;
    logic                 wb_req;
    logic [ADDR_BITS-1:0] wb_address;
    logic [LINE_BITS-1:0] wb_data;
    logic [LINE_BITS-1:0] data_to_write;
    logic                 data_valid;
    logic                 wb_ack;
    logic                 busy;

    modport master (
        output ask_for_data, address, wb_req, wb_address, wb_data,
        input  data_to_write, data_valid, wb_ack, busy
    );

    modport slave (
        input  ask_for_data, address, wb_req, wb_address, wb_data,
        output data_to_write, data_valid, wb_ack, busy
    );
endinterface

// File: rtl/main_memory_responder_line_array.sv
// Single-port line store: one access per cycle, registered read data.
// Read data holds its previous value on write cycles so an earlier read survives a write.
module mem_line_array #(
    parameter int DEPTH     = 1024,
    parameter int LINE_BITS = 512,
    parameter int IDX_BITS  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_BITS-1:0]  idx,
    input  logic [LINE_BITS-1:0] wdata,
    output logic [LINE_BITS-1:0] rdata
);
    logic [LINE_BITS-1:0] ram [DEPTH];
    logic [LINE_BITS-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            ram[idx] <= wdata;
        end else begin
            rdata_reg <= ram[idx];
        end
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency line memory serving cache refills and dirty-line write-backs.
// A fill arriving together with a write-back is held and started right after the write-back.
module main_memory_responder #(
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 4,
    parameter int LINE_BITS = mem_if_pkg::LINE_BITS
) (
    input logic                     clk,
    input logic                     rst,
    main_memory_responder_if.slave  bus
);
    import mem_if_pkg::*;

    localparam int IDX_BITS = $clog2(DEPTH);

    mem_state_t           state_reg;
    logic [3:0]           cnt_reg;
    logic                 rd_pending_reg;
    logic                 from_wb_reg;
    logic [IDX_BITS-1:0]  fill_idx_reg;
    logic [IDX_BITS-1:0]  wb_idx_reg;
    logic [LINE_BITS-1:0] wb_data_reg;
    logic [LINE_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 ack_reg;
    logic                 busy_reg;

    logic                 done;
    logic                 ram_we;
    logic [IDX_BITS-1:0]  ram_idx;
    logic [LINE_BITS-1:0] ram_rdata;
    logic [IDX_BITS-1:0]  req_idx;
    logic [IDX_BITS-1:0]  req_wb_idx;

    assign done       = (cnt_reg == 4'(LATENCY));
    assign req_idx    = bus.address[OFFSET_BITS +: IDX_BITS];
    assign req_wb_idx = bus.wb_address[OFFSET_BITS +: IDX_BITS];

    // The port reads the fill line every non-write cycle, so the data is ready at completion
    // even with LATENCY=1 (the read then happens on the accepting edge).
    always_comb begin
        ram_we  = (state_reg == WR_WAIT) && done && !rst;
        ram_idx = fill_idx_reg;
        if (state_reg == IDLE) begin
            ram_idx = req_idx;
        end
        if (ram_we) begin
            ram_idx = wb_idx_reg;
        end
    end

    mem_line_array #(
        .DEPTH     (DEPTH),
        .LINE_BITS (LINE_BITS),
        .IDX_BITS  (IDX_BITS)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (wb_data_reg),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            rd_pending_reg <= 1'b0;
            from_wb_reg    <= 1'b0;
            fill_idx_reg   <= '0;
            wb_idx_reg     <= '0;
            wb_data_reg    <= '0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            ack_reg        <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            ack_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    from_wb_reg <= 1'b0;
                    if (bus.wb_req) begin
                        wb_idx_reg  <= req_wb_idx;
                        wb_data_reg <= bus.wb_data;
                        cnt_reg     <= 4'd1;
                        busy_reg    <= 1'b1;
                        state_reg   <= WR_WAIT;
                        if (bus.ask_for_data) begin
                            rd_pending_reg <= 1'b1;
                            fill_idx_reg   <= req_idx;
                        end
                    end else if (bus.ask_for_data) begin
                        fill_idx_reg <= req_idx;
                        cnt_reg      <= 4'd1;
                        busy_reg     <= 1'b1;
                        state_reg    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (done) begin
                        // A chained fill may have read its line before the write-back landed.
                        data_reg    <= (from_wb_reg && fill_idx_reg == wb_idx_reg)
                                       ? wb_data_reg : ram_rdata;
                        valid_reg   <= 1'b1;
                        busy_reg    <= 1'b0;
                        cnt_reg     <= '0;
                        from_wb_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                WR_WAIT: begin
                    if (done) begin
                        ack_reg <= 1'b1;
                        if (rd_pending_reg) begin
                            rd_pending_reg <= 1'b0;
                            from_wb_reg    <= 1'b1;
                            cnt_reg        <= 4'd1;
                            state_reg      <= RD_WAIT;
                        end else begin
                            busy_reg  <= 1'b0;
                            cnt_reg   <= '0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.data_to_write = data_reg;
    assign bus.data_valid    = valid_reg;
    assign bus.wb_ack        = ack_reg;
    assign bus.busy          = busy_reg;
endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Line-granular main-memory model answering the cache's refill and write-back requests. Receives a line-fill request (`ask_for_data` plus address) or a dirty-line write-back, and completes each after a fixed latency. Serves 512-bit lines from an internal array. Sits between the 4-way cache and the system bus; it is the responder side of the cache's miss/write-back handshake.

## Interface
- `DEPTH`, 1024: lines held in the backing array; power of two.
- `LATENCY`, 4: cycles from request acceptance to completion; legal range is 1 to 15.
- `LINE_BITS`, 512: line width in bits (64-byte block).
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `ask_for_data`, input, 1: line-fill request; level-sampled in IDLE.
- `address`, input, 32: fill address; bits [5:0] ignored.
- `wb_req`, input, 1: write-back request; level-sampled in IDLE.
- `wb_address`, input, 32: write-back address; bits [5:0] ignored.
- `wb_data`, input, LINE_BITS: dirty line to store.
- `data_to_write`, output, LINE_BITS: fill data returned to the cache.
- `data_valid`, output, 1: one-cycle pulse; `data_to_write` is valid while it is high.
- `wb_ack`, output, 1: one-cycle pulse; write-back committed.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- Line index is `addr[6 +: log2(DEPTH)]`. Higher address bits alias.
- FSM states:
  - IDLE: the only state where requests are accepted.
  - RD_WAIT: fill in progress.
  - WR_WAIT: write-back in progress.
- Request acceptance in IDLE:
  - `wb_req`=1: capture `wb_address` and `wb_data`, then go to WR_WAIT.
  - Else if `ask_for_data`=1: capture `address`, then go to RD_WAIT.
  - Both high: write-back wins. Set `rd_pending` and capture `address` in the same edge.
- Capture registers: separate fill and write-back address registers, plus the write-back data register.
- Counter `cnt` (4 bits):
  - Loads 1 on acceptance.
  - Increments each cycle in a WAIT state.
  - Completion fires on the edge where `cnt`==LATENCY.
- RD_WAIT completion:
  - Register `data_to_write` from the array line and pulse `data_valid`.
  - Return to IDLE.
- WR_WAIT completion:
  - Write the array line and pulse `wb_ack`.
  - If `rd_pending`, clear it, reload `cnt`, and go straight to RD_WAIT using the stored fill address. Otherwise go to IDLE.
- Requests arriving while `busy`=1 are ignored (not queued), except the single pending fill above.
- Read after write-back to the same line returns the new data.
- `data_to_write` holds its last value between pulses.

## Timing
- Reset values:
  - `data_to_write`=0; `data_valid`, `wb_ack`, `busy`=0.
  - FSM=IDLE, `cnt`=0, `rd_pending`=0.
  - Array contents are not reset.
- Reset asserted mid-operation: the transaction is abandoned with no pulse, the array write is skipped, and the pending fill is dropped.
- Latency: a request sampled at edge N gives a pulse visible after edge N+LATENCY, lasting exactly one cycle.
- `busy` rises after edge N and falls after edge N+LATENCY. A new request is accepted at the earliest at edge N+LATENCY+1.
- Combined write-back + fill accepted at edge N:
  - `wb_ack` after edge N+LATENCY.
  - `data_valid` after edge N+2·LATENCY.
  - `busy` stays high continuously.
- LATENCY=1: acceptance at N, pulse after N+1. The FSM still passes through the WAIT state for one cycle.

## Structure
- Package `mem_if_pkg` holds:
  - `LINE_BITS`=512, `OFFSET_BITS`=6, `ADDR_BITS`=32.
  - State enum `mem_state_t` {IDLE, RD_WAIT, WR_WAIT}.
- Sub-module `mem_line_array`: single-port synchronous array of DEPTH×LINE_BITS.
  - Write enable, index, write data, registered read data.
  - The responder arbitrates the port: one access per cycle, read data used at completion.
- The FSM, counter and capture registers stay in the top level.

## Test plan
- Reset with `rst`=1 for 3 cycles → all outputs 0, `busy`=0; release → `busy` stays 0 with no requests.
- Write-back to 0x0000_1040 with data = {16{32'hDEADBEEF}}, LATENCY=4 → `wb_ack` pulses exactly 4 cycles after acceptance. Then fill from 0x0000_107F → `data_valid` after 4 cycles with the same pattern.
- `wb_req` and `ask_for_data` high together (wb 0x40 = all-ones, fill 0x80 preloaded 0x1234…) → `wb_ack` at +4, `data_valid` at +8 with line 0x80 data, `busy` high throughout.
- `ask_for_data` pulsed again at +2 during a fill → ignored: only one `data_valid`, and `busy` falls at +4.
- Reset asserted at +2 of a write-back → no `wb_ack`; a following fill of that line returns its old contents.
- Aliasing with DEPTH=1024: write 0x0001_0040, read 0x0000_0040 → same data returned.
